// File: rtl/star_data_server.sv
// star_data_server
// Memory-side responder for the STAR datapath byte-fetch interface.
// A host preloads a 2**AW x DW image buffer, pulses load_done, and the
// server then answers the consumer's reads with one cycle of latency until
// the consumer strobes finish. Protocol misuse raises a sticky err flag.
//
// state  | meaning
// -------+-------------------------------------------------------------
// LOAD   | buffer writable through the load port, reads refused
// READY  | image loaded, waiting for the first consumer read
// SERVE  | answering consumer reads, one per cycle while data_req high
// DONE   | consumer finished; outputs frozen until reset

module star_data_server #(
  parameter int AW = 9,
  parameter int DW = 8,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          load_done,
  input  logic          data_req,
  input  logic [AW-1:0] data_addr,
  output logic [DW-1:0] data,
  input  logic          finish,
  output logic          ready,
  output logic          done,
  output logic [CW-1:0] req_count,
  output logic          err
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_READY = 2'd1,
    S_SERVE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  // Image buffer has no reset so a reload after reset can reuse its contents.
  logic [DW-1:0] mem [DEPTH];

  logic serve;
  logic mem_we;
  logic err_set;

  // Request qualification and error detection from the current state.
  always_comb begin
    serve   = data_req && ((state_q == S_READY) || (state_q == S_SERVE));
    mem_we  = load_en && (state_q == S_LOAD);
    err_set = (data_req && ((state_q == S_LOAD) || (state_q == S_DONE)))
            || (load_en && (state_q != S_LOAD));
  end

  // Next-state and next-value logic for the FSM and its registered outputs.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = err_q | err_set;

    unique case (state_q)
      S_LOAD:  if (load_done) state_d = S_READY;
      S_READY: if (data_req)  state_d = S_SERVE;
      S_SERVE: if (finish)    state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase

    if (serve) begin
      data_d = mem[data_addr];
      // Saturate rather than wrap so a long run never reports a small count.
      if (count_q != {CW{1'b1}}) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // FSM state plus data/count/err registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Buffer write port, only honoured while loading.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  // Moore status decode straight from the state register.
  always_comb begin
    ready = (state_q == S_READY) || (state_q == S_SERVE);
    done  = (state_q == S_DONE);
  end

  assign data      = data_q;
  assign req_count = count_q;
  assign err       = err_q;

endmodule

// File: doc/star_data_server.md
Name: star_data_server

Overview:
- Memory-side responder for the byte-fetch interface used by the STAR datapath. The consumer drives data_req/data_addr and this block returns data.
- Holds a 512 x 8 image buffer. A testbench or host preloads it through a write port, then serves the consumer's sequential reads.
- Counts served requests and watches the consumer's finish strobe.
- Sits between the image/pattern loader and the STAR core.

Parameters:
- AW, 9, address width; buffer depth is 2**AW.
- DW, 8, data width.
- CW, 10, request-counter width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_en  input  1  write strobe into the buffer.
- load_addr  input  AW  write address.
- load_data  input  DW  write data.
- load_done  input  1  one-cycle pulse; image loading is complete.
- data_req  input  1  consumer read request, level; one read per cycle while high.
- data_addr  input  AW  consumer read address.
- data  output  DW  read data, registered.
- finish  input  1  consumer completion strobe.
- ready  output  1  buffer loaded; server is accepting reads.
- done  output  1  consumer has signalled finish.
- req_count  output  CW  number of reads served.
- err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - state=LOAD; data=0; ready=0; done=0; req_count=0; err=0.
  - Buffer contents are not cleared by reset and are retained.
- States:
  - LOAD->READY on load_done.
  - READY->SERVE on data_req.
  - SERVE->DONE on finish.
  - DONE is terminal until reset.
- LOAD:
  - load_en high: mem[load_addr]<=load_data on that edge.
  - load_en and load_done in the same cycle: the write is performed and the state moves to READY.
  - data_req in LOAD: not served; err<=1.
- READY:
  - ready=1.
  - data_req high: the read is served in that same cycle (data<=mem[data_addr]), req_count increments, and the state moves to SERVE.
- SERVE:
  - ready=1.
  - Every cycle with data_req=1: data<=mem[data_addr]. Value is visible the cycle after the address is sampled (latency 1). req_count+1.
  - Cycles with data_req=0: data holds its previous value; count unchanged.
  - finish=1: state moves to DONE. A data_req in the same cycle is still served and counted.
- DONE:
  - done=1, ready=0.
  - data holds its last value; req_count frozen.
  - data_req in DONE: not served; err<=1.
- load_en in READY/SERVE/DONE: write is ignored (buffer unchanged); err<=1.
- load_done outside LOAD: ignored, no error.
- finish outside SERVE: ignored.
- req_count saturates at 2**CW-1; no wrap.
- Addresses are full AW width; all 512 locations are valid. No sequential-address checking.
- err is sticky until reset.
- reset asserted mid-SERVE: all outputs return to their reset values immediately (asynchronous). Buffer contents survive, but a new load_done is required before reads are served again.
- Outputs ready, done are decoded from state (Moore). data, req_count, err are registers.

Test Plan:
- Load mem[k]=k+8'h10 for k=0..15, pulse load_done, then drive data_req with data_addr 0..15 on consecutive cycles -> data = 8'h10..8'h1F, each one cycle after its address; ready=1; req_count=16.
- After the 16 reads, assert finish for one cycle -> done=1 and ready=0 next cycle. A further data_req -> data unchanged, req_count stays 16, err=1.
- data_req asserted before load_done -> data stays 0, req_count=0, err=1, state stays LOAD. After load_done, a read of addr 9'd511 (loaded 8'hA5) -> data=8'hA5.
- Gapped requests in SERVE (req high/low alternating) -> data holds between reads. req_count counts only high cycles. finish coinciding with a req -> that read is served and counted.
- load_en with addr 5 / data 8'hFF during SERVE -> mem[5] keeps its old value on a subsequent read; err=1.
- Assert reset mid-SERVE between clock edges -> data=0, req_count=0, ready=0 immediately. Reload via load_done only (no writes), then read addr 3 -> original preloaded value returned.
